// File: rtl/immediate_operand_encoder.sv
// Iterative search for the canonical rotated 8-bit immediate encoding of a
// 32-bit constant: one rotation amount (2*r) is tried per clock cycle.
module immediate_operand_encoder #(
    parameter int EARLY_EXIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        encodable,
    output logic [7:0]  imm8,
    output logic [3:0]  rotate,
    output logic [11:0] instr_field,
    output logic        carry_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] value_r;
    logic [3:0]  r_r;
    logic        found_r;
    logic [7:0]  hit_imm_r;
    logic [3:0]  hit_rot_r;
    logic        busy_r;
    logic        done_r;
    logic        encodable_r;
    logic [7:0]  imm8_r;
    logic [3:0]  rotate_r;
    logic [11:0] instr_field_r;
    logic        carry_out_r;

    logic [31:0] cand_s;
    logic        match_s;
    logic        last_s;
    logic        sel_enc_s;
    logic [7:0]  sel_imm_s;
    logic [3:0]  sel_rot_s;
    logic        sel_carry_s;

    // 32-bit circular left rotate; the doubled word keeps every bit in play
    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {v, v} << amt;
        return dbl[63:32];
    endfunction

    // Candidate for the current rotation and the result that would be loaded on exit
    always_comb begin
        cand_s      = rol32(value_r, {r_r, 1'b0});
        match_s     = (cand_s[31:8] == 24'd0);
        last_s      = (r_r == 4'd15) || ((EARLY_EXIT != 0) && match_s);
        sel_enc_s   = 1'b0;
        sel_imm_s   = 8'd0;
        sel_rot_s   = 4'd0;
        if (found_r) begin
            sel_enc_s = 1'b1;
            sel_imm_s = hit_imm_r;
            sel_rot_s = hit_rot_r;
        end else if (match_s) begin
            sel_enc_s = 1'b1;
            sel_imm_s = cand_s[7:0];
            sel_rot_s = r_r;
        end else begin
            sel_enc_s = 1'b0;
        end
        // A non-zero rotation makes the decoded shifter carry equal result bit 31
        sel_carry_s = sel_enc_s && (sel_rot_s != 4'd0) && value_r[31];
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            value_r       <= 32'd0;
            r_r           <= 4'd0;
            found_r       <= 1'b0;
            hit_imm_r     <= 8'd0;
            hit_rot_r     <= 4'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            encodable_r   <= 1'b0;
            imm8_r        <= 8'd0;
            rotate_r      <= 4'd0;
            instr_field_r <= 12'd0;
            carry_out_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        value_r <= value;
                        r_r     <= 4'd0;
                        found_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Only the first (smallest r) match is kept in full-scan mode
                    if (match_s && !found_r) begin
                        found_r   <= 1'b1;
                        hit_imm_r <= cand_s[7:0];
                        hit_rot_r <= r_r;
                    end
                    if (last_s) begin
                        state_r       <= DONE;
                        busy_r        <= 1'b0;
                        encodable_r   <= sel_enc_s;
                        imm8_r        <= sel_imm_s;
                        rotate_r      <= sel_rot_s;
                        instr_field_r <= {sel_rot_s, sel_imm_s};
                        carry_out_r   <= sel_carry_s;
                    end else begin
                        r_r <= r_r + 4'd1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign encodable   = encodable_r;
    assign imm8        = imm8_r;
    assign rotate      = rotate_r;
    assign instr_field = instr_field_r;
    assign carry_out   = carry_out_r;

endmodule
